// File: rtl/ram_pkg.sv
// Shared constants for the general-purpose data bank and its benches.
package ram_pkg;

    // Default geometry: 4096 words of 32 bits.
    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 12;

    // Encoding of the single read/write-select line.
    localparam logic R_WN_READ  = 1'b1;
    localparam logic R_WN_WRITE = 1'b0;

endpackage : ram_pkg

// File: rtl/ram.sv
// Single-port synchronous RAM with a registered read port.
// Writes and reads complete on the rising edge. data_out only changes on
// read cycles (no-change behaviour on writes) and is cleared
// asynchronously by rst_n. The array itself is never cleared by reset.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r_wn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage array; starts out all zeros for simulation and FPGA init.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic wr_en;
    logic rd_en;

    // Operations are suppressed while reset is held low.
    assign wr_en = rst_n && (r_wn == R_WN_WRITE);
    assign rd_en = (r_wn == R_WN_READ);

    // Array write port: full-word write on every write-select cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[address] <= data_in;
        end
    end

    // Output register: captures the addressed word on reads, holds on writes,
    // clears immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= mem[address];
        end
    end

endmodule : ram

// File: tb/tb_ram.sv
// Self-checking bench for ram: table-driven read/write vectors with a
// scoreboard queue, plus hand-written reset sequences.
module tb_ram;
    import ram_pkg::*;

    localparam int DATA_W = RAM_DATA_W;
    localparam int ADDR_W = RAM_ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              r_wn;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    int checks;
    int failures;

    typedef struct {
        logic              r_wn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] exp;
        string             name;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] sb_q[$];

    ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r_wn     (r_wn),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: data_out=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Drive one operation between edges, push its expected output, then
    // pop and compare just after the edge.
    task automatic do_op(input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp,
                         input string name);
        logic [DATA_W-1:0] e;
        @(negedge clk);
        r_wn    = rw;
        address = a;
        data_in = d;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, data_out, e);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        r_wn     = R_WN_READ;
        address  = '0;
        data_in  = '0;

        // Reset held: output is zero; a write attempted during reset is dropped.
        #2;
        check("reset_async", data_out, 32'h0);
        @(negedge clk);
        r_wn = R_WN_WRITE; address = 12'h000; data_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("reset_hold_wr", data_out, 32'h0);
        @(negedge clk);
        r_wn = R_WN_READ; address = 12'h3A5; data_in = 32'h1234_5678;
        @(posedge clk); #1;
        check("reset_hold_rd", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{R_WN_READ,  12'h000, 32'h0,         32'h0000_0000, "powerup_rd0"});
        vecs.push_back('{R_WN_WRITE, 12'h000, 32'hABCD_0123, 32'h0000_0000, "wr0_hold"});
        vecs.push_back('{R_WN_WRITE, 12'h001, 32'hFFEE_DDCC, 32'h0000_0000, "wr1_hold"});
        vecs.push_back('{R_WN_READ,  12'h000, 32'h0,         32'hABCD_0123, "rd0"});
        vecs.push_back('{R_WN_READ,  12'h001, 32'h0,         32'hFFEE_DDCC, "rd1"});
        vecs.push_back('{R_WN_WRITE, 12'h000, 32'h0123_4567, 32'hFFEE_DDCC, "ovw0_hold"});
        vecs.push_back('{R_WN_READ,  12'h000, 32'h0,         32'h0123_4567, "ovw0_rd"});
        vecs.push_back('{R_WN_READ,  12'h001, 32'h0,         32'hFFEE_DDCC, "rd1_again"});
        vecs.push_back('{R_WN_WRITE, 12'h002, 32'h55AA_55AA, 32'hFFEE_DDCC, "wr2_hold"});
        vecs.push_back('{R_WN_READ,  12'h002, 32'h0,         32'h55AA_55AA, "rd2_raw"});
        vecs.push_back('{R_WN_WRITE, 12'hFFF, 32'hDEAD_BEEF, 32'h55AA_55AA, "wrfff_hold"});
        vecs.push_back('{R_WN_WRITE, 12'h000, 32'h1234_5678, 32'h55AA_55AA, "wr0b_hold"});
        vecs.push_back('{R_WN_READ,  12'hFFF, 32'h0,         32'hDEAD_BEEF, "rd_fff"});
        vecs.push_back('{R_WN_READ,  12'h000, 32'h0,         32'h1234_5678, "rd_000"});
        vecs.push_back('{R_WN_READ,  12'h800, 32'h0,         32'h0000_0000, "rd_800_zero"});
        vecs.push_back('{R_WN_WRITE, 12'h010, 32'hCAFE_F00D, 32'h0000_0000, "wr10_hold"});
        vecs.push_back('{R_WN_READ,  12'h010, 32'h0,         32'hCAFE_F00D, "rd10"});

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].r_wn, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);
        end

        // Reset pulse between edges: output clears immediately; a write
        // presented across an edge during reset must not land.
        @(negedge clk);
        r_wn = R_WN_WRITE; address = 12'h010; data_in = 32'h0BAD_0BAD;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_async", data_out, 32'h0);
        @(posedge clk); #1;
        check("midrun_reset_held", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        r_wn  = R_WN_READ;

        do_op(R_WN_READ, 12'h010, 32'h0, 32'hCAFE_F00D, "retain10");
        do_op(R_WN_READ, 12'hFFF, 32'h0, 32'hDEAD_BEEF, "retain_fff");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule : tb_ram
